// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage state, default widths and per-stage control bundles
package pipe_pkg;
    typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, SKID = 2'd2} stage_state_t;
    localparam int DATA_W_DEF = 160;
    localparam int CTRL_W_DEF = 16;
    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       halted;
        logic [3:0] rsvd;
    } ex_ctrl_t;
    typedef struct packed {
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        mem_to_reg;
        logic        halted;
        logic [10:0] rsvd;
    } mem_ctrl_t;
    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg;
        logic        halted;
        logic [12:0] rsvd;
    } wb_ctrl_t;
    function automatic logic [1:0] occ_of(stage_state_t s);
        return s == FULL ? 2'd1 : s == SKID ? 2'd2 : 2'd0;
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating event counter with synchronous clear priority
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= clr ? '0 : (inc && cnt != '1) ? cnt + W'(1) : cnt;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with skid entry, stall, flush and bubble stats
module pipe_stage_skid import pipe_pkg::*; #(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int CTRL_W    = CTRL_W_DEF,
    parameter int ZERO_CTRL = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  bubble_cnt
);
    stage_state_t      state;
    logic              ready_en;
    logic [DATA_W-1:0] main_d, skid_d;
    logic [CTRL_W-1:0] main_c, skid_c;
    logic              in_fire, out_fire;
    always_comb begin
        in_ready  = !stall && state != SKID && ready_en;
        out_valid = !stall && (state == FULL || state == SKID);
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        out_data  = main_d;
        out_ctrl  = (ZERO_CTRL != 0 && !out_valid) ? '0 : main_c;
        occupancy = occ_of(state);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            ready_en <= 1'b0;
            main_d   <= '0;
            main_c   <= '0;
            skid_d   <= '0;
            skid_c   <= '0;
        end else begin
            ready_en <= 1'b1;
            if (flush)
                state <= EMPTY;
            else
                case (state)
                    EMPTY: if (in_fire) begin
                        state  <= FULL;
                        main_d <= in_data;
                        main_c <= in_ctrl;
                    end
                    FULL: if (in_fire && out_fire) begin
                        main_d <= in_data;
                        main_c <= in_ctrl;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end else if (in_fire) begin
                        state  <= SKID;
                        skid_d <= in_data;
                        skid_c <= in_ctrl;
                    end
                    SKID: if (out_fire) begin
                        state  <= FULL;
                        main_d <= skid_d;
                        main_c <= skid_c;
                    end
                    default: state <= EMPTY;
                endcase
        end
    end
    sat_counter #(.W(CNT_W)) u_bubble (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (out_ready && !out_valid && !stall),
        .clr  (cnt_clr),
        .cnt  (bubble_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed and random checks against a queue-based reference model
module tb_pipe_stage_skid;
    localparam int DW = 64;
    localparam int CW = 16;
    localparam int NW = 4;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0, flush = 1'b0, in_valid = 1'b1, out_ready = 1'b0, cnt_clr = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [CW-1:0] in_ctrl = '0;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [1:0]    occupancy;
    logic [NW-1:0] bubble_cnt;
    int total = 0, bad = 0;
    logic [DW+CW-1:0] q[$];
    int  cnt_m = 0;
    bit  rel = 0;

    pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .ZERO_CTRL(1), .CNT_W(NW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
        .occupancy(occupancy), .cnt_clr(cnt_clr), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit exp_in_ready();
        return rel && !stall && q.size() < 2;
    endfunction
    function automatic bit exp_out_valid();
        return !stall && q.size() > 0;
    endfunction
    function automatic logic [CW-1:0] exp_ctrl();
        return exp_out_valid() ? q[0][CW-1:0] : '0;
    endfunction
    function automatic logic [DW-1:0] exp_data();
        return q.size() > 0 ? q[0][DW+CW-1:CW] : '0;
    endfunction

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                         input logic ordy, input logic st, input logic fl, input logic clr);
        @(negedge clk);
        in_valid = iv; in_data = d; in_ctrl = c; out_ready = ordy;
        stall = st; flush = fl; cnt_clr = clr;
        #1;
    endtask

    task automatic tick();
        bit inf, outf;
        inf  = in_valid && exp_in_ready();
        outf = exp_out_valid() && out_ready;
        if (cnt_clr) cnt_m = 0;
        else if (out_ready && !exp_out_valid() && !stall && cnt_m < (1 << NW) - 1) cnt_m++;
        if (flush) q.delete();
        else begin
            if (outf) void'(q.pop_front());
            if (inf) q.push_back({in_data, in_ctrl});
        end
        @(posedge clk);
        rel = rst_n;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
        total++; if (bubble_cnt !== '0) begin bad++; $display("FAIL rst_bubble got=%0d exp=0", bubble_cnt); end
        rst_n = 1'b1; #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL release_in_ready got=%b exp=0", in_ready); end
        tick();
        drive(0, '0, '0, 0, 0, 0, 0);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_release_in_ready got=%b exp=1", in_ready); end
        total++; if (occupancy !== 2'd0) begin bad++; $display("FAIL post_release_occ got=%0d exp=0", occupancy); end
    endtask

    task automatic test_basic();
        drive(1, 64'hA5, 16'h0003, 0, 0, 0, 0);
        tick();
        drive(0, '0, '0, 0, 0, 0, 0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        total++; if (out_data !== 64'hA5) begin bad++; $display("FAIL basic_data got=%h exp=a5", out_data); end
        total++; if (out_ctrl !== 16'h0003) begin bad++; $display("FAIL basic_ctrl got=%h exp=0003", out_ctrl); end
        total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL basic_occ got=%0d exp=1", occupancy); end
        drive(0, '0, '0, 1, 0, 0, 0);
        tick();
    endtask

    task automatic test_skid_fill();
        drive(1, 64'h11, 16'h0101, 0, 0, 0, 0); tick();
        drive(1, 64'h22, 16'h0202, 0, 0, 0, 0); tick();
        drive(0, '0, '0, 0, 0, 0, 0);
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL skid_occ got=%0d exp=2", occupancy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL skid_in_ready got=%b exp=0", in_ready); end
        drive(0, '0, '0, 1, 0, 0, 0);
        total++; if (out_data !== 64'h11) begin bad++; $display("FAIL skid_first got=%h exp=11", out_data); end
        total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL skid_occ2 got=%0d exp=2", occupancy); end
        tick();
        drive(0, '0, '0, 1, 0, 0, 0);
        total++; if (out_data !== 64'h22 || out_valid !== 1'b1) begin bad++; $display("FAIL skid_second got=%h/%b exp=22/1", out_data, out_valid); end
        total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL skid_occ1 got=%0d exp=1", occupancy); end
        tick();
        drive(0, '0, '0, 1, 0, 0, 0);
        total++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL skid_drained got=%0d/%b exp=0/0", occupancy, out_valid); end
        tick();
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 9; i++) begin
            drive(i <= 8, DW'(i), CW'(i), 1, 0, 0, 0);
            if (i <= 8) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready[%0d] got=%b exp=1", i, in_ready); end
            end
            if (i > 1) begin
                total++; if (out_valid !== 1'b1 || out_data !== DW'(i - 1)) begin bad++; $display("FAIL stream_data[%0d] got=%h/%b exp=%0d/1", i, out_data, out_valid, i - 1); end
                total++; if (occupancy !== 2'd1) begin bad++; $display("FAIL stream_occ[%0d] got=%0d exp=1", i, occupancy); end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        drive(1, 64'h33, 16'h8001, 0, 0, 0, 0); tick();
        drive(1, 64'h44, 16'h8002, 0, 0, 0, 0); tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 64'h99, 16'hFFFF, 1, 1, 0, 0);
            total++; if (out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b0) begin bad++; $display("FAIL stall_outs[%0d] got=%b/%h/%b exp=0/0/0", i, out_valid, out_ctrl, in_ready); end
            total++; if (occupancy !== 2'd2) begin bad++; $display("FAIL stall_occ[%0d] got=%0d exp=2", i, occupancy); end
            tick();
        end
        drive(0, '0, '0, 1, 0, 0, 0);
        total++; if (out_data !== 64'h33 || out_ctrl !== 16'h8001) begin bad++; $display("FAIL stall_first got=%h/%h exp=33/8001", out_data, out_ctrl); end
        tick();
        drive(0, '0, '0, 1, 0, 0, 0);
        total++; if (out_data !== 64'h44 || out_ctrl !== 16'h8002) begin bad++; $display("FAIL stall_second got=%h/%h exp=44/8002", out_data, out_ctrl); end
        tick();
    endtask

    task automatic test_flush();
        drive(1, 64'h55, 16'h0055, 0, 0, 0, 0); tick();
        drive(1, 64'h66, 16'h0066, 0, 0, 0, 0); tick();
        drive(1, 64'h77, 16'h0077, 1, 1, 1, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, '0, 1, 0, 0, 0);
            total++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_empty[%0d] got=%0d/%b exp=0/0", i, occupancy, out_valid); end
            tick();
        end
    endtask

    task automatic test_counter();
        drive(0, '0, '0, 0, 0, 0, 1); tick();
        for (int i = 0; i < 10; i++) begin drive(0, '0, '0, 1, 0, 0, 0); tick(); end
        drive(0, '0, '0, 0, 0, 0, 0);
        total++; if (bubble_cnt !== 4'd10) begin bad++; $display("FAIL cnt_10 got=%0d exp=10", bubble_cnt); end
        for (int i = 0; i < 10; i++) begin drive(0, '0, '0, 1, 0, 0, 0); tick(); end
        drive(0, '0, '0, 0, 0, 0, 0);
        total++; if (bubble_cnt !== 4'd15) begin bad++; $display("FAIL cnt_sat got=%0d exp=15", bubble_cnt); end
        drive(0, '0, '0, 1, 0, 0, 1); tick();
        drive(0, '0, '0, 0, 0, 0, 0);
        total++; if (bubble_cnt !== 4'd0) begin bad++; $display("FAIL cnt_clr got=%0d exp=0", bubble_cnt); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, CW'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 19) == 0, $urandom_range(0, 15) == 0);
            total++; if (out_valid !== exp_out_valid()) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, out_valid, exp_out_valid()); end
            total++; if (in_ready !== exp_in_ready()) begin bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, in_ready, exp_in_ready()); end
            total++; if (occupancy !== 2'(q.size())) begin bad++; $display("FAIL rnd_occ[%0d] got=%0d exp=%0d", i, occupancy, q.size()); end
            total++; if (out_ctrl !== exp_ctrl()) begin bad++; $display("FAIL rnd_ctrl[%0d] got=%h exp=%h", i, out_ctrl, exp_ctrl()); end
            total++; if (bubble_cnt !== NW'(cnt_m)) begin bad++; $display("FAIL rnd_bubble[%0d] got=%0d exp=%0d", i, bubble_cnt, cnt_m); end
            if (q.size() > 0) begin
                total++; if (out_data !== exp_data()) begin bad++; $display("FAIL rnd_data[%0d] got=%h exp=%h", i, out_data, exp_data()); end
            end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        drive(1, 64'hC1, 16'h00C1, 0, 0, 0, 0); tick();
        drive(1, 64'hC2, 16'h00C2, 0, 0, 0, 0); tick();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; #1;
        q.delete(); cnt_m = 0; rel = 0;
        total++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin bad++; $display("FAIL midrst got=%0d/%b/%b exp=0/0/0", occupancy, out_valid, in_ready); end
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; #1;
        tick();
        drive(0, '0, '0, 1, 0, 0, 0);
        total++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin bad++; $display("FAIL midrst_after got=%b/%0d exp=0/0", out_valid, occupancy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b exp=1", in_ready); end
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_skid_fill();
        test_streaming();
        test_stall();
        test_flush();
        test_counter();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Generic, parametrised inter-stage pipeline register (ID/EX, EX/MEM, MEM/WB) replacing the hand-written per-stage copy registers.
- Carries one data bundle and one control bundle under a valid/ready handshake.
- A one-entry skid buffer keeps in_ready registered (independent of out_ready).
- Adds a stall hold, a synchronous flush that squashes to a bubble, control zeroing on bubbles, and occupancy/bubble statistics.

Parameters:
- DATA_W, 160, width of the data bundle (operands, PC+4, immediate, register addresses).
- CTRL_W, 16, width of the control bundle (alu_op, reg_write, mem write, halted, ...).
- ZERO_CTRL, 1, when 1, out_ctrl is forced to 0 whenever out_valid=0.
- CNT_W, 16, width of the saturating bubble counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  freeze the stage: no acceptance, no presentation, contents held (replaces cache_done).
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream data bundle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  presented data (main register).
- out_ctrl  out  CTRL_W  presented control (main register, zero-gated per ZERO_CTRL).
- occupancy  out  2  entries held: 0, 1 or 2.
- cnt_clr  in  1  synchronous clear of bubble_cnt.
- bubble_cnt  out  CNT_W  saturating count of bubble cycles.

Behaviour:
- Reset (rst_n=0, asynchronous): state=EMPTY; main and skid data/ctrl = 0; bubble_cnt = 0.
  - Outputs during reset: out_valid=0, in_ready=0, occupancy=0.
  - in_ready rises on the first clock edge after reset release, never combinationally during reset.
  - Reset mid-transfer discards both entries.
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Combinational outputs:
  - in_ready = !stall & (state != SKID) & reset released.
  - out_valid = !stall & (state != EMPTY).
- Three-state FSM, latency 1 cycle from in_fire to out_valid:
  - EMPTY
    - in_fire -> FULL; main <= in.
  - FULL
    - in_fire & out_fire -> FULL; main <= in.
    - out_fire only -> EMPTY.
    - in_fire only -> SKID; skid <= in.
    - neither -> hold.
  - SKID (in_ready=0)
    - out_fire -> FULL; main <= skid.
    - otherwise hold.
- Ordering: entries leave strictly in arrival order. The skid entry never bypasses main.
- Stall: no fires occur; state, main and skid are held. Stall lasting many cycles loses nothing.
- Flush:
  - State -> EMPTY next cycle, discarding main and skid.
  - Data registers are not cleared (only the valid state).
  - Flush overrides stall and any simultaneous in_fire/out_fire; the same-cycle in_fire entry is also discarded.
  - out_fire on a flush cycle is still a legal downstream acceptance of the current main entry. Downstream owns qualifying it with flush.
- Bubble zeroing: ZERO_CTRL=1 and out_valid=0 -> out_ctrl = 0 (no reg_write/mem write on bubbles). out_data is always main.
- occupancy: EMPTY=0, FULL=1, SKID=2, reported from state regardless of stall.
- bubble_cnt:
  - Increments by 1 in each cycle with out_ready=1, out_valid=0 and stall=0.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority over increment and clears to 0 next cycle.
- Illegal state encoding recovers to EMPTY.

Decomposition:
- Shared package pipe_pkg:
  - State enum stage_state_t {EMPTY, FULL, SKID}.
  - Default widths DATA_W_DEF and CTRL_W_DEF.
  - Per-stage control bundle typedefs, packed to CTRL_W.
- One natural sub-module: sat_counter (CNT_W-wide, inc/clr, saturating), reused by the other stages' statistics.

Test Plan:
- Reset/basic: rst_n=0 with in_valid=1 -> out_valid=0, in_ready=0, occupancy=0. Release; push data=0xA5, ctrl=0x0003 -> out_valid=1 next cycle, out_data=0xA5, out_ctrl=0x0003.
- Skid fill:
  - out_ready=0; push 0x11, 0x22 -> after the 2nd push, occupancy=2 and in_ready=0.
  - out_ready=1 -> 0x11 then 0x22 delivered on consecutive cycles, occupancy 2->1->0.
- Streaming: in_valid=out_ready=1 for 8 cycles with data 1..8 -> out_data 1..8 in order, one per cycle, in_ready constantly 1, occupancy stays 1.
- Stall: occupancy=2, stall=1 for 5 cycles with out_ready=1 -> out_valid=0, out_ctrl=0, in_ready=0, no data lost. Stall=0 -> both entries delivered in order.
- Flush priority: occupancy=2, flush=stall=in_valid=1 together -> next cycle occupancy=0, out_valid=0. No entry (including the pushed one) ever appears.
- Counter: out_ready=1, no input for 10 cycles -> bubble_cnt=10. With CNT_W=4, after 20 cycles it is 15. cnt_clr=1 -> 0 next cycle.
